// File: rtl/alu_seq_pkg.sv
// Purpose: shared types and widths for the ALU sequencer (state encoding, command bundle, counter width).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_seq_pkg;

    localparam int WIDTH_P     = 4;
    localparam int NREGS_P     = 4;
    localparam int AW_P        = (NREGS_P > 1) ? $clog2(NREGS_P) : 1;
    localparam int OP_W        = 3;
    localparam int ALU_LAT_MAX = 7;
    localparam int CNT_W       = $clog2(ALU_LAT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } seq_state_e;

    // One upstream command as presented on the cmd_* pins.
    typedef struct packed {
        logic              ld;
        logic [OP_W-1:0]   op;
        logic [AW_P-1:0]   rd;
        logic [AW_P-1:0]   rs1;
        logic [AW_P-1:0]   rs0;
        logic              usec;
        logic [WIDTH_P-1:0] imm;
    } seq_cmd_t;

endpackage

// File: rtl/alu_sequencer_regfile.sv
// Purpose: NREGS x WIDTH register file, async clear, one sync write port, three combinational read ports.
// Latency: write visible on reads the cycle after the write edge; reads are combinational.
// Backpressure: none, always accepts a write.
// Ports: clk/rstn; we_i/waddr_i/wdata_i write port; raddr1_i/rdata1_o, raddr0_i/rdata0_o, raddr_dbg_i/rdata_dbg_o reads.
module seq_regfile #(
    parameter int WIDTH = 4,
    parameter int NREGS = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr1_i,
    output logic [WIDTH-1:0] rdata1_o,
    input  logic [AW-1:0]    raddr0_i,
    output logic [WIDTH-1:0] rdata0_o,
    input  logic [AW-1:0]    raddr_dbg_i,
    output logic [WIDTH-1:0] rdata_dbg_o
);

    logic [WIDTH-1:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (int'(waddr_i) < NREGS)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Addresses beyond NREGS (non power-of-two depth) read as zero.
    assign rdata1_o    = (int'(raddr1_i)    < NREGS) ? mem_q[raddr1_i]    : '0;
    assign rdata0_o    = (int'(raddr0_i)    < NREGS) ? mem_q[raddr0_i]    : '0;
    assign rdata_dbg_o = (int'(raddr_dbg_i) < NREGS) ? mem_q[raddr_dbg_i] : '0;

endmodule

// File: rtl/alu_sequencer.sv
// Purpose: accepts load/ALU commands, drives a clocked ALU from a small register file and writes results back.
// Latency: load writes on the accept edge; ALU op writes ALU_LAT+1 edges after accept; done follows each write.
// Backpressure: cmd_ready only in IDLE, so one ALU op in flight; loads sustain one per cycle.
// Ports: cmd_* command handshake in, alu_* operand/result pair to the ALU, done/result/carry status,
//        dbg_addr/dbg_data combinational register-file peek.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH   = WIDTH_P,
    parameter  int NREGS   = NREGS_P,
    parameter  int ALU_LAT = 1,
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_ld,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_rs1,
    input  logic [AW-1:0]    cmd_rs0,
    input  logic             cmd_usec,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in0,
    output logic             alu_cin,
    output logic [OP_W-1:0]  alu_instr,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cout,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [WIDTH-1:0] in1_q, in1_d, in0_q, in0_d;
    logic             cin_q, cin_d;
    logic [OP_W-1:0]  instr_q, instr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             done_q;

    seq_cmd_t         cmd_in;
    logic             accept;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [WIDTH-1:0] rs1_data, rs0_data;

    // The command bundle is sized by the package defaults; WIDTH/NREGS overrides must match them.
    assign cmd_in = '{ld: cmd_ld, op: cmd_op, rd: cmd_rd, rs1: cmd_rs1, rs0: cmd_rs0,
                      usec: cmd_usec, imm: cmd_imm};

    // Gated by rstn so ready is low for the whole time reset is held.
    assign cmd_ready = rstn && (state_q == IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // Single write port shared by loads (accept edge) and ALU writeback (WB exit edge);
    // the two never coincide because nothing is accepted outside IDLE.
    assign rf_we    = (accept && cmd_in.ld) || (state_q == WB);
    assign rf_waddr = (state_q == WB) ? rd_q    : cmd_in.rd;
    assign rf_wdata = (state_q == WB) ? alu_out : cmd_in.imm;

    seq_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_regfile (
        .clk         (clk),
        .rstn        (rstn),
        .we_i        (rf_we),
        .waddr_i     (rf_waddr),
        .wdata_i     (rf_wdata),
        .raddr1_i    (cmd_in.rs1),
        .rdata1_o    (rs1_data),
        .raddr0_i    (cmd_in.rs0),
        .rdata0_o    (rs0_data),
        .raddr_dbg_i (dbg_addr),
        .rdata_dbg_o (dbg_data)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        in1_d    = in1_q;
        in0_d    = in0_q;
        cin_d    = cin_q;
        instr_d  = instr_q;
        result_d = result_q;
        carry_d  = carry_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_in.ld) begin
                        result_d = cmd_in.imm;
                    end else begin
                        // Operands are snapshotted here, so rd may alias rs1/rs0 safely
                        // and the ALU sees stable inputs for the whole ISSUE cycle.
                        state_d = ISSUE;
                        rd_d    = cmd_in.rd;
                        in1_d   = rs1_data;
                        in0_d   = rs0_data;
                        cin_d   = cmd_in.usec & carry_q;
                        instr_d = cmd_in.op;
                    end
                end
            end
            ISSUE: begin
                if (ALU_LAT > 1) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(ALU_LAT - 1);
                end else begin
                    state_d = WB;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WB: begin
                state_d  = IDLE;
                result_d = alu_out;
                carry_d  = alu_cout;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rd_q     <= '0;
            in1_q    <= '0;
            in0_q    <= '0;
            cin_q    <= 1'b0;
            instr_q  <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            in1_q    <= in1_d;
            in0_q    <= in0_d;
            cin_q    <= cin_d;
            instr_q  <= instr_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            done_q   <= rf_we;
        end
    end

    assign alu_in1   = in1_q;
    assign alu_in0   = in0_q;
    assign alu_cin   = cin_q;
    assign alu_instr = instr_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry     = carry_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Purpose: self-checking bench for alu_sequencer; two instances (ALU_LAT=1 and ALU_LAT=3) with adder stub ALUs.
// Latency: stub ALUs are registered pipelines of depth 1 and 3.
// Backpressure: commands wait on cmd_ready with a bounded cycle budget.
module tb_alu_sequencer;

    localparam int W     = 4;
    localparam int NR    = 4;
    localparam int AW    = 2;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic [1:0]    vld, rdy, cin, cout, done, carry;
    logic          c_ld, c_usec;
    logic [2:0]    c_op;
    logic [AW-1:0] c_rd, c_rs1, c_rs0, dbg_addr;
    logic [W-1:0]  c_imm;
    logic [W-1:0]  in1 [2];
    logic [W-1:0]  in0 [2];
    logic [W-1:0]  aout [2];
    logic [W-1:0]  res [2];
    logic [W-1:0]  dbg [2];
    logic [2:0]    instr [2];

    alu_sequencer #(.WIDTH(W), .NREGS(NR), .ALU_LAT(LAT_A)) u_seq_a (
        .clk(clk), .rstn(rstn), .cmd_valid(vld[0]), .cmd_ready(rdy[0]),
        .cmd_ld(c_ld), .cmd_op(c_op), .cmd_rd(c_rd), .cmd_rs1(c_rs1), .cmd_rs0(c_rs0),
        .cmd_usec(c_usec), .cmd_imm(c_imm),
        .alu_in1(in1[0]), .alu_in0(in0[0]), .alu_cin(cin[0]), .alu_instr(instr[0]),
        .alu_out(aout[0]), .alu_cout(cout[0]),
        .done(done[0]), .result(res[0]), .carry(carry[0]),
        .dbg_addr(dbg_addr), .dbg_data(dbg[0])
    );

    alu_sequencer #(.WIDTH(W), .NREGS(NR), .ALU_LAT(LAT_B)) u_seq_b (
        .clk(clk), .rstn(rstn), .cmd_valid(vld[1]), .cmd_ready(rdy[1]),
        .cmd_ld(c_ld), .cmd_op(c_op), .cmd_rd(c_rd), .cmd_rs1(c_rs1), .cmd_rs0(c_rs0),
        .cmd_usec(c_usec), .cmd_imm(c_imm),
        .alu_in1(in1[1]), .alu_in0(in0[1]), .alu_cin(cin[1]), .alu_instr(instr[1]),
        .alu_out(aout[1]), .alu_cout(cout[1]),
        .done(done[1]), .result(res[1]), .carry(carry[1]),
        .dbg_addr(dbg_addr), .dbg_data(dbg[1])
    );

    // Stub ALUs: out/cout = in1 + in0 + cin, delayed by the instance's latency.
    logic [W:0] pa;
    logic [W:0] pb [3];
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pa    <= '0;
            pb[0] <= '0;
            pb[1] <= '0;
            pb[2] <= '0;
        end else begin
            pa    <= {1'b0, in1[0]} + {1'b0, in0[0]} + {{W{1'b0}}, cin[0]};
            pb[0] <= {1'b0, in1[1]} + {1'b0, in0[1]} + {{W{1'b0}}, cin[1]};
            pb[1] <= pb[0];
            pb[2] <= pb[1];
        end
    end
    assign aout[0] = pa[W-1:0];
    assign cout[0] = pa[W];
    assign aout[1] = pb[2][W-1:0];
    assign cout[1] = pb[2][W];

    // Reference model: architectural register contents and carry flag per instance.
    logic [W-1:0] m_reg [2][NR];
    logic         m_carry [2];
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int lat_of(input int s);
        return (s == 0) ? LAT_A : LAT_B;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            m_carry[s] = 1'b0;
            for (int r = 0; r < NR; r++) m_reg[s][r] = '0;
        end
    endtask

    task automatic chk_regs(input int s, input string tag);
        for (int r = 0; r < NR; r++) begin
            dbg_addr = AW'(r);
            #1;
            chk(tag, int'(dbg[s]), int'(m_reg[s][r]));
        end
    endtask

    // Issue one command to instance s and check its complete effect.
    task automatic send(input int s, input bit ld, input int op, input int rd, input int rs1,
                        input int rs0, input bit usec, input int imm);
        int           n;
        int           edges;
        logic [W-1:0] a, b, oldv;
        logic         ci;
        logic [W:0]   sum;
        c_ld   = ld;
        c_op   = 3'(op);
        c_rd   = AW'(rd);
        c_rs1  = AW'(rs1);
        c_rs0  = AW'(rs0);
        c_usec = usec;
        c_imm  = W'(imm);
        vld[s] = 1'b1;
        n = 0;
        while (!rdy[s] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy[s]) begin
            chk("accept_timeout", int'(rdy[s]), 1);
            vld[s] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        vld[s] = 1'b0;
        if (ld) begin
            m_reg[s][rd] = W'(imm);
            @(negedge clk);
            chk("ld_done", int'(done[s]), 1);
            chk("ld_result", int'(res[s]), imm & 15);
        end else begin
            a    = m_reg[s][rs1];
            b    = m_reg[s][rs0];
            ci   = usec & m_carry[s];
            oldv = m_reg[s][rd];
            sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            dbg_addr = AW'(rd);
            @(negedge clk);
            chk("issue_in1", int'(in1[s]), int'(a));
            chk("issue_in0", int'(in0[s]), int'(b));
            chk("issue_cin", int'(cin[s]), int'(ci));
            chk("issue_instr", int'(instr[s]), op & 7);
            edges = 0;
            while (!done[s] && edges < 20) begin
                chk("busy_rdy", int'(rdy[s]), 0);
                chk("hold_in1", int'(in1[s]), int'(a));
                chk("hold_in0", int'(in0[s]), int'(b));
                chk("pre_write_dbg", int'(dbg[s]), int'(oldv));
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
            chk("latency", edges, lat_of(s) + 1);
            m_reg[s][rd] = sum[W-1:0];
            m_carry[s]   = sum[W];
            chk("alu_result", int'(res[s]), int'(sum[W-1:0]));
            chk("alu_carry", int'(carry[s]), int'(sum[W]));
            chk("wb_dbg", int'(dbg[s]), int'(sum[W-1:0]));
        end
    endtask

    initial begin
        int ld_rd [3];
        int ld_im [3];
        int s, gap;
        rstn = 1'b0;
        vld = '0; c_ld = 0; c_op = '0; c_rd = '0; c_rs1 = '0; c_rs0 = '0;
        c_usec = 0; c_imm = '0; dbg_addr = '0;
        model_clear();

        // Reset state.
        @(negedge clk);
        chk("rst_rdy_a", int'(rdy[0]), 0);
        chk("rst_rdy_b", int'(rdy[1]), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(res[0]), 0);
        chk("rst_in1", int'(in1[0]), 0);
        #2 rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy_a", int'(rdy[0]), 1);
        chk("post_rst_rdy_b", int'(rdy[1]), 1);
        chk_regs(0, "post_rst_dbg_a");
        chk_regs(1, "post_rst_dbg_b");

        // Back-to-back loads, one per cycle with no stall.
        ld_rd[0] = 0; ld_im[0] = 1;
        ld_rd[1] = 1; ld_im[1] = 2;
        ld_rd[2] = 3; ld_im[2] = 11;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            c_ld = 1'b1; c_rd = AW'(ld_rd[k]); c_imm = W'(ld_im[k]); vld[0] = 1'b1;
            @(negedge clk);
            chk("b2b_rdy", int'(rdy[0]), 1);
            if (k > 0) begin
                chk("b2b_done", int'(done[0]), 1);
                chk("b2b_result", int'(res[0]), ld_im[k-1]);
            end
            @(posedge clk);
            #1;
            m_reg[0][ld_rd[k]] = W'(ld_im[k]);
        end
        vld[0] = 1'b0;
        @(negedge clk);
        chk("b2b_last_done", int'(done[0]), 1);
        chk("b2b_last_result", int'(res[0]), 11);
        @(negedge clk);
        chk("b2b_done_drop", int'(done[0]), 0);
        chk_regs(0, "b2b_dbg");

        // Directed ALU ops on the latency-1 instance: add, carry chain, carry-in use, aliasing.
        send(0, 0, 1, 2, 0, 1, 0, 0);
        send(0, 1, 0, 1, 0, 0, 0, 10);
        send(0, 0, 1, 0, 3, 1, 0, 0);
        send(0, 0, 2, 0, 0, 0, 1, 0);
        send(0, 1, 0, 1, 0, 0, 0, 4);
        send(0, 0, 5, 1, 1, 1, 0, 0);
        chk_regs(0, "directed_dbg");

        // Latency-3 instance: same add, done four edges after accept.
        send(1, 1, 0, 0, 0, 0, 0, 1);
        send(1, 1, 0, 1, 0, 0, 0, 2);
        send(1, 0, 1, 2, 0, 1, 0, 0);

        // Randomized mix across both instances.
        for (int i = 0; i < 40; i++) begin
            s   = int'($urandom_range(0, 1));
            send(s, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)),
                 int'($urandom_range(0, NR - 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 15)));
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("idle_done", int'(done[s]), 0);
                chk("idle_rdy", int'(rdy[s]), 1);
            end
            if (i % 8 == 7) chk_regs(s, "rand_dbg");
        end

        // Reset held for 5 ns while the latency-3 instance is in WAIT.
        @(posedge clk);
        #1;
        c_ld = 0; c_op = 3'd6; c_rd = 2'd3; c_rs1 = 2'd1; c_rs0 = 2'd2; c_usec = 1; vld[1] = 1'b1;
        @(posedge clk);
        #1 vld[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("wait_rst_rdy", int'(rdy[1]), 0);
        chk("wait_rst_done", int'(done[1]), 0);
        chk("wait_rst_result", int'(res[1]), 0);
        chk("wait_rst_carry", int'(carry[1]), 0);
        chk("wait_rst_in1", int'(in1[1]), 0);
        chk("wait_rst_in0", int'(in0[1]), 0);
        chk("wait_rst_cin", int'(cin[1]), 0);
        chk("wait_rst_instr", int'(instr[1]), 0);
        #4 rstn = 1'b1;
        model_clear();
        @(negedge clk);
        chk("wait_rel_rdy", int'(rdy[1]), 1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("wait_rel_no_done", int'(done[1]), 0);
        end
        chk_regs(1, "wait_rel_dbg");

        // Reset during WB: no write, no done pulse.
        send(0, 1, 0, 1, 0, 0, 0, 4);
        c_ld = 0; c_op = 3'd1; c_rd = 2'd1; c_rs1 = 2'd1; c_rs0 = 2'd1; c_usec = 0; vld[0] = 1'b1;
        @(posedge clk);
        #1 vld[0] = 1'b0;
        @(posedge clk);
        #2 rstn = 1'b0;
        #5 rstn = 1'b1;
        model_clear();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("wb_rst_no_done", int'(done[0]), 0);
        end
        chk_regs(0, "wb_rst_dbg");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
